// File: rtl/tproc_isa_pkg.sv
// Shared ISA definitions for the instruction dispatch path.
// Holds:
//   - the instruction width,
//   - the opcode constants recognised by the sequencer,
//   - the sequencer FSM state encoding,
//   - a helper that extracts the opcode byte from an instruction.
package tproc_isa_pkg;

    localparam int INSTR_W = 64;

    localparam logic [7:0] OP_FETCH_A = 8'h01;
    localparam logic [7:0] OP_FETCH_B = 8'h02;
    localparam logic [7:0] OP_FETCH_C = 8'h04;
    localparam logic [7:0] OP_CONV    = 8'h81;
    localparam logic [7:0] OP_REGCFG  = 8'h40;
    localparam logic [7:0] OP_END     = 8'h82;
    localparam logic [7:0] OP_HOLD    = 8'h44;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_CHECK,
        ST_ISSUE,
        ST_GUARD,
        ST_HOLD,
        ST_DONE
    } seq_state_t;

    function automatic logic [7:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 8];
    endfunction

endpackage

// File: rtl/instr_dispatch_sequencer_if.sv
// Instruction memory read port plus decoder issue port of the sequencer.
//   instr_mem_rd_en / instr_mem_addr : read strobe and address (sequencer -> memory)
//   instr_mem_data                   : read data, valid one cycle after rd_en
//   instruction / instr_enable       : issued word and one-cycle strobe (sequencer -> decoder)
// master = sequencer side, slave = memory/decoder side.
interface instr_dispatch_sequencer_if #(
    parameter int ADDR_W = 10
);
    import tproc_isa_pkg::*;

    logic                 instr_mem_rd_en;
    logic [ADDR_W-1:0]    instr_mem_addr;
    logic [INSTR_W-1:0]   instr_mem_data;
    logic [INSTR_W-1:0]   instruction;
    logic                 instr_enable;

    modport master (
        output instr_mem_rd_en, instr_mem_addr, instruction, instr_enable,
        input  instr_mem_data
    );

    modport slave (
        input  instr_mem_rd_en, instr_mem_addr, instruction, instr_enable,
        output instr_mem_data
    );

endinterface

// File: rtl/instr_hazard_check.sv
// Combinational opcode classification and issue permit.
//   opcode        : instruction opcode byte
//   fetch_busy    : any operand fetcher busy
//   compute_busy  : CLP busy
//   permit        : instruction may issue this cycle
//   is_end/is_hold: opcode is end-of-program / verification hold
module instr_hazard_check
    import tproc_isa_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic       fetch_busy,
    input  logic       compute_busy,
    output logic       permit,
    output logic       is_end,
    output logic       is_hold
);

    logic need_fetch;
    logic need_compute;

    always_comb begin
        need_fetch   = 1'b0;
        need_compute = 1'b0;
        case (opcode)
            OP_FETCH_A, OP_FETCH_B, OP_FETCH_C: need_fetch = 1'b1;
            OP_CONV, OP_REGCFG, OP_END: begin
                need_fetch   = 1'b1;
                need_compute = 1'b1;
            end
            // hold and unknown opcodes never wait
            default: ;
        endcase
    end

    assign permit  = !(need_fetch && fetch_busy) && !(need_compute && compute_busy);
    assign is_end  = (opcode == OP_END);
    assign is_hold = (opcode == OP_HOLD);

endmodule

// File: rtl/instr_dispatch_sequencer.sv
// Program sequencer in front of the instruction decoder.
// Reads instructions from start_addr, waits out fetch/CLP hazards, issues each
// one as a single-cycle instr_enable, then idles GUARD_CYC cycles so the
// decoder's busy flags are visible before the next hazard check.
//   clk, rst           : clock, synchronous active-high reset
//   start, start_addr  : launch pulse and first address (honoured in IDLE/DONE)
//   resume             : releases a hold (honoured in HOLD)
//   bus                : instruction memory read port + decoder issue port
//   fetch_busy         : OR of fetcher busy flags
//   compute_busy       : CLP busy
//   busy, held, done   : status
//   pc                 : next read address
//   issued_count       : saturating issue count since last start
module instr_dispatch_sequencer
    import tproc_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int GUARD_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic                         resume,
    instr_dispatch_sequencer_if.master   bus,
    input  logic                         fetch_busy,
    input  logic                         compute_busy,
    output logic                         busy,
    output logic                         held,
    output logic                         done,
    output logic [ADDR_W-1:0]            pc,
    output logic [CNT_W-1:0]             issued_count
);

    localparam int GC_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    seq_state_t         state, state_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_out;
    logic [GC_W-1:0]    guard_cnt;
    logic               guard_last;
    logic               permit, is_end, is_hold;

    instr_hazard_check u_hazard (
        .opcode       (opcode_of(instr_q)),
        .fetch_busy   (fetch_busy),
        .compute_busy (compute_busy),
        .permit       (permit),
        .is_end       (is_end),
        .is_hold      (is_hold)
    );

    assign guard_last = (guard_cnt == GC_W'(GUARD_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_READ;
            ST_READ:          state_nxt = ST_CAPTURE;
            ST_CAPTURE:       state_nxt = ST_CHECK;
            ST_CHECK:         if (permit) state_nxt = ST_ISSUE;
            ST_ISSUE:         state_nxt = ST_GUARD;
            ST_GUARD: begin
                if (guard_last) begin
                    if (is_end)       state_nxt = ST_DONE;
                    else if (is_hold) state_nxt = ST_HOLD;
                    else              state_nxt = ST_READ;
                end
            end
            ST_HOLD:          if (resume) state_nxt = ST_READ;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.instr_mem_rd_en = (state == ST_READ);
        bus.instr_enable    = (state == ST_ISSUE);
        busy                = (state != ST_IDLE) && (state != ST_DONE);
        held                = (state == ST_HOLD);
        done                = (state == ST_DONE);
    end

    // pc is only zero after reset, so driving the address unconditionally
    // still gives an all-zero port while idle after reset.
    assign bus.instr_mem_addr = pc;
    assign bus.instruction    = instr_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            issued_count <= '0;
            instr_q      <= '0;
            instr_out    <= '0;
            guard_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pc           <= start_addr;
                        issued_count <= '0;
                    end
                end
                ST_CAPTURE: instr_q <= bus.instr_mem_data;
                // Load the output word on the way into ISSUE so it is
                // already stable while instr_enable is high.
                ST_CHECK:   if (permit) instr_out <= instr_q;
                ST_ISSUE: begin
                    pc        <= pc + ADDR_W'(1);
                    guard_cnt <= '0;
                    if (~&issued_count) issued_count <= issued_count + CNT_W'(1);
                end
                ST_GUARD:   guard_cnt <= guard_cnt + GC_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_dispatch_sequencer.sv
module tb_instr_dispatch_sequencer;
    import tproc_isa_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int GUARD_CYC = 3;
    localparam int CNT_W     = 16;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int MAXC      = 600;

    logic clk = 1'b0;
    logic rst, start, resume, fetch_busy, compute_busy;
    logic [ADDR_W-1:0] start_addr, pc;
    logic busy, held, done;
    logic [CNT_W-1:0] issued_count;

    instr_dispatch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_dispatch_sequencer #(
        .ADDR_W(ADDR_W), .GUARD_CYC(GUARD_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .resume(resume), .bus(bus), .fetch_busy(fetch_busy),
        .compute_busy(compute_busy), .busy(busy), .held(held), .done(done),
        .pc(pc), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    // instruction memory: registered read, data one cycle after rd_en
    logic [63:0] mem [DEPTH];
    always @(posedge clk)
        if (bus.instr_mem_rd_en) bus.instr_mem_data <= mem[bus.instr_mem_addr];

    int n_chk = 0, n_fail = 0, cyc = 0, done_seen = -1;
    bit fb_w [MAXC];
    bit cb_w [MAXC];
    int                iss_cyc [$];
    logic [63:0]       iss_ins [$];
    logic [ADDR_W-1:0] rd_q    [$];
    logic [7:0] ops [7] = '{8'h01, 8'h02, 8'h04, 8'h81, 8'h40, 8'h13, 8'hFF};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit wave_f(input int c);
        return (c >= 0 && c < MAXC) ? fb_w[c] : 1'b0;
    endfunction
    function automatic bit wave_c(input int c);
        return (c >= 0 && c < MAXC) ? cb_w[c] : 1'b0;
    endfunction

    // which busy flags each opcode must wait for
    function automatic bit permit_ref(input logic [7:0] op, input bit f, input bit c);
        bit nf, nc;
        nf = op inside {OP_FETCH_A, OP_FETCH_B, OP_FETCH_C, OP_CONV, OP_REGCFG, OP_END};
        nc = op inside {OP_CONV, OP_REGCFG, OP_END};
        return !(nf && f) && !(nc && c);
    endfunction

    // one clock; cycle k values are driven and observed 1 time unit after edge k
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fetch_busy   = wave_f(cyc);
        compute_busy = wave_c(cyc);
        if (bus.instr_enable) begin
            iss_cyc.push_back(cyc);
            iss_ins.push_back(bus.instruction);
        end
        if (bus.instr_mem_rd_en) rd_q.push_back(bus.instr_mem_addr);
        if (done && done_seen < 0) done_seen = cyc;
    endtask

    task automatic clear_waves();
        for (int k = 0; k < MAXC; k++) begin
            fb_w[k] = 1'b0;
            cb_w[k] = 1'b0;
        end
    endtask

    task automatic clear_obs();
        iss_cyc.delete();
        iss_ins.delete();
        rd_q.delete();
        done_seen = -1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] sa);
        start      = 1'b1;
        start_addr = sa;
        cyc        = 0;
        step();
        start      = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"},   busy, 0);
        check({tag, ".held"},   held, 0);
        check({tag, ".done"},   done, 0);
        check({tag, ".pc"},     pc, 0);
        check({tag, ".cnt"},    issued_count, 0);
        check({tag, ".rd_en"},  bus.instr_mem_rd_en, 0);
        check({tag, ".addr"},   bus.instr_mem_addr, 0);
        check({tag, ".en"},     bus.instr_enable, 0);
        check({tag, ".instr"},  bus.instruction, 0);
    endtask

    // Timeline model: each instruction is read 2 cycles before its first
    // hazard check, issues the cycle after the first permitted check, and the
    // next read follows GUARD_CYC idle cycles after the issue.
    task automatic run_prog(input logic [ADDR_W-1:0] sa, input int n, input string tag);
        int exp_c [$];
        logic [63:0] exp_i [$];
        logic [ADDR_W-1:0] exp_a [$];
        logic [ADDR_W-1:0] a, epc;
        int t, c, last;
        t = 1;
        last = 0;
        for (int i = 0; i < n; i++) begin
            a = sa + ADDR_W'(i);
            exp_a.push_back(a);
            exp_i.push_back(mem[a]);
            c = t + 2;
            while (!permit_ref(mem[a][63:56], wave_f(c), wave_c(c))) c++;
            exp_c.push_back(c + 1);
            last = c + 1;
            t = c + 2 + GUARD_CYC;
        end
        clear_obs();
        do_start(sa);
        while (done_seen < 0 && cyc < last + GUARD_CYC + 20) begin
            // a start while busy must change nothing
            start = (cyc == 4);
            start_addr = ~sa;
            step();
        end
        start = 1'b0;
        check({tag, ".n_issue"}, iss_cyc.size(), n);
        for (int i = 0; i < n && i < iss_cyc.size(); i++) begin
            check($sformatf("%s.issue_cyc%0d", tag, i), iss_cyc[i], exp_c[i]);
            check($sformatf("%s.issue_ins%0d", tag, i), iss_ins[i], exp_i[i]);
        end
        check({tag, ".n_read"}, rd_q.size(), n);
        for (int i = 0; i < n && i < rd_q.size(); i++)
            check($sformatf("%s.rd_addr%0d", tag, i), rd_q[i], exp_a[i]);
        check({tag, ".done_cyc"}, done_seen, last + GUARD_CYC + 1);
        epc = sa + ADDR_W'(n);
        check({tag, ".pc"},    pc, epc);
        check({tag, ".cnt"},   issued_count, n);
        check({tag, ".busy"},  busy, 0);
        check({tag, ".instr"}, bus.instruction, exp_i[n-1]);
    endtask

    function automatic logic [63:0] word(input logic [7:0] op);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[63:56] = op;
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, nrd;
        logic [ADDR_W-1:0] sa;
        rst = 1'b1; start = 1'b0; resume = 1'b0; start_addr = '0;
        fetch_busy = 1'b0; compute_busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) mem[k] = word(8'h13);
        clear_waves();
        repeat (3) step();
        check_zero("reset");
        rst = 1'b0;
        step();

        // basic three-instruction program
        mem[10'h010] = word(OP_FETCH_C);
        mem[10'h011] = word(OP_CONV);
        mem[10'h012] = word(OP_END);
        run_prog(10'h010, 3, "basic");
        check("basic.first", iss_cyc.size() > 0 ? iss_cyc[0] : -1, 4);
        check("basic.pc_abs", pc, 10'h013);

        // fetch hazard held for 20 cycles
        clear_waves();
        for (int k = 3; k < 23; k++) fb_w[k] = 1'b1;
        mem[10'h040] = word(OP_FETCH_B);
        mem[10'h041] = word(OP_END);
        run_prog(10'h040, 2, "fetch_stall");
        check("fetch_stall.abs", iss_cyc.size() > 0 ? iss_cyc[0] : -1, 24);

        // compute hazard stalls CONV but not FETCH_A
        clear_waves();
        for (int k = 1; k < 16; k++) cb_w[k] = 1'b1;
        for (int k = 20; k < 41; k++) cb_w[k] = 1'b1;
        mem[10'h080] = word(OP_CONV);
        mem[10'h081] = word(OP_FETCH_A);
        mem[10'h082] = word(OP_END);
        run_prog(10'h080, 3, "comp_stall");
        check("comp_stall.fa_abs", iss_cyc.size() > 1 ? iss_cyc[1] : -1, 24);

        // address wrap
        clear_waves();
        mem[10'h3FF] = word(OP_FETCH_A);
        mem[10'h000] = word(OP_END);
        run_prog(10'h3FF, 2, "wrap");

        // hold / resume
        clear_waves();
        mem[10'h100] = word(OP_HOLD);
        mem[10'h101] = word(OP_FETCH_C);
        mem[10'h102] = word(OP_END);
        clear_obs();
        do_start(10'h100);
        while (cyc < 8) begin
            resume = (cyc == 5);   // during GUARD: must be ignored
            step();
        end
        resume = 1'b0;
        check("hold.held", held, 1);
        check("hold.busy", busy, 1);
        check("hold.issue_cyc", iss_cyc.size() > 0 ? iss_cyc[0] : -1, 4);
        repeat (5) step();
        check("hold.still_held", held, 1);
        check("hold.no_rd", rd_q.size(), 1);
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("hold.resume_rd", bus.instr_mem_rd_en, 1);
        check("hold.resume_addr", bus.instr_mem_addr, 10'h101);
        check("hold.released", held, 0);
        for (int k = 0; k < 40 && done_seen < 0; k++) step();
        check("hold.done", done, 1);
        check("hold.cnt", issued_count, 3);
        nrd = rd_q.size();
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
        check("hold.resume_in_done", done, 1);
        check("hold.no_rd_in_done", rd_q.size(), nrd);

        // reset while stalled in CHECK, with a simultaneous start
        clear_waves();
        for (int k = 1; k < MAXC; k++) fb_w[k] = 1'b1;
        mem[10'h200] = word(OP_FETCH_A);
        clear_obs();
        do_start(10'h200);
        while (cyc < 5) step();
        check("rst_chk.busy_before", busy, 1);
        rst = 1'b1; start = 1'b1; start_addr = 10'h155;
        step();
        check_zero("rst_chk");
        rst = 1'b0; start = 1'b0;
        nrd = rd_q.size();
        repeat (3) step();
        check("rst_chk.idle", busy, 0);
        check("rst_chk.no_rd", rd_q.size(), nrd);
        check("rst_chk.no_issue", iss_cyc.size(), 0);

        // reset during GUARD
        clear_waves();
        mem[10'h210] = word(OP_FETCH_C);
        clear_obs();
        do_start(10'h210);
        while (cyc < 6) step();
        rst = 1'b1;
        step();
        check_zero("rst_grd");
        rst = 1'b0;
        nrd = rd_q.size();
        repeat (4) step();
        check("rst_grd.no_rd", rd_q.size(), nrd);
        check("rst_grd.issues", iss_cyc.size(), 1);

        // randomized programs and busy activity
        for (int it = 0; it < 8; it++) begin
            n  = $urandom_range(2, 6);
            sa = ADDR_W'($urandom_range(0, DEPTH - 1));
            for (int i = 0; i < n - 1; i++)
                mem[sa + ADDR_W'(i)] = word(ops[$urandom_range(0, 6)]);
            mem[sa + ADDR_W'(n - 1)] = word(OP_END);
            clear_waves();
            for (int k = 1; k < MAXC; k++) begin
                fb_w[k] = ($urandom_range(0, 3) == 0);
                cb_w[k] = ($urandom_range(0, 2) == 0);
            end
            run_prog(sa, n, $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
